// File: rtl/bridge_pkg.sv
// Shared types and default address map for the P-series CPU peripheral bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        BR_IDLE   = 2'd0,
        BR_ACCESS = 2'd1,
        BR_RESP   = 2'd2
    } br_state_t;

    localparam int N_DEV_MAX = 8;

    localparam logic [31:0] DM_LSA     = 32'h0000_0000;
    localparam logic [31:0] DM_MSA     = 32'h0000_2FFF;
    localparam logic [31:0] TIMER0_LSA = 32'h0000_7F00;
    localparam logic [31:0] TIMER0_MSA = 32'h0000_7F0B;
    localparam logic [31:0] TIMER1_LSA = 32'h0000_7F10;
    localparam logic [31:0] TIMER1_MSA = 32'h0000_7F1B;
    localparam logic [31:0] INT_LSA    = 32'h0000_7F20;
    localparam logic [31:0] INT_MSA    = 32'h0000_7F23;

endpackage

// File: rtl/bridge_decode.sv
// Address window decoder: one-hot hit vector with lowest-index priority and a miss flag.
module bridge_decode
    import bridge_pkg::*;
#(
    parameter int                   N_DEV   = 4,
    parameter logic [N_DEV*32-1:0]  DEV_LSA = {INT_LSA, TIMER1_LSA, TIMER0_LSA, DM_LSA},
    parameter logic [N_DEV*32-1:0]  DEV_MSA = {INT_MSA, TIMER1_MSA, TIMER0_MSA, DM_MSA}
) (
    input  logic [31:0]      addr,
    output logic [N_DEV-1:0] hit,
    output logic             miss
);

    logic [31:0] lsa;
    logic [31:0] msa;
    logic        found;

    always_comb begin
        hit   = '0;
        found = 1'b0;
        lsa   = '0;
        msa   = '0;
        for (int i = 0; i < N_DEV; i++) begin
            lsa = DEV_LSA[i*32 +: 32];
            msa = DEV_MSA[i*32 +: 32];
            // Offset form of lsa <= addr <= msa; relies on msa >= lsa for every window.
            if (!found && ((addr - lsa) <= (msa - lsa))) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = !found;
    end

endmodule

// File: rtl/bus_bridge_mux.sv
// Handshaked CPU-to-peripheral bridge: decodes an access, forwards it to one device
// channel, waits for its acknowledge (or a timeout) and returns a registered response.
module bus_bridge_mux
    import bridge_pkg::*;
#(
    parameter int                   N_DEV   = 4,
    parameter logic [N_DEV*32-1:0]  DEV_LSA = {INT_LSA, TIMER1_LSA, TIMER0_LSA, DM_LSA},
    parameter logic [N_DEV*32-1:0]  DEV_MSA = {INT_MSA, TIMER1_MSA, TIMER0_MSA, DM_MSA},
    parameter int                   TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pr_req,
    input  logic [31:0]           pr_addr,
    input  logic [31:0]           pr_wd,
    input  logic [3:0]            pr_we,
    output logic                  pr_ready,
    output logic [31:0]           pr_rd,
    output logic                  pr_err,
    output logic [31:0]           err_addr,
    output logic [7:0]            err_cnt,
    output logic [31:0]           dev_addr,
    output logic [31:0]           dev_wd,
    output logic [3:0]            dev_we,
    output logic [N_DEV-1:0]      dev_sel,
    input  logic [N_DEV-1:0]      dev_ack,
    input  logic [N_DEV*32-1:0]   dev_rd
);

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    br_state_t         state_q;
    br_state_t         state_d;
    logic [31:0]       addr_q;
    logic [31:0]       wd_q;
    logic [3:0]        we_q;
    logic [N_DEV-1:0]  sel_q;
    logic [31:0]       rd_q;
    logic              err_q;
    logic [7:0]        wait_q;
    logic [31:0]       err_addr_q;
    logic [7:0]        err_cnt_q;

    logic [N_DEV-1:0]  hit;
    logic              miss;
    logic              ack_sel;
    logic              expired;
    logic              in_access;
    logic [31:0]       rd_mux;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    bridge_decode #(
        .N_DEV   (N_DEV),
        .DEV_LSA (DEV_LSA),
        .DEV_MSA (DEV_MSA)
    ) u_decode (
        .addr (pr_addr),
        .hit  (hit),
        .miss (miss)
    );

    // sel_q is one-hot in ACCESS, so OR-ing the masked slices selects one channel.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (sel_q[i]) begin
                rd_mux = rd_mux | dev_rd[i*32 +: 32];
            end
        end
    end

    assign ack_sel   = |(dev_ack & sel_q);
    assign expired   = (wait_q == TIMEOUT_W);
    assign in_access = (state_q == BR_ACCESS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BR_IDLE:   if (pr_req) state_d = miss ? BR_RESP : BR_ACCESS;
            BR_ACCESS: if (ack_sel || expired) state_d = BR_RESP;
            BR_RESP:   state_d = BR_IDLE;
            default:   state_d = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            wd_q       <= '0;
            we_q       <= '0;
            sel_q      <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            wait_q     <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            case (state_q)
                BR_IDLE: begin
                    if (pr_req) begin
                        addr_q <= pr_addr;
                        wd_q   <= pr_wd;
                        we_q   <= pr_we;
                        sel_q  <= hit;
                        wait_q <= '0;
                        rd_q   <= '0;
                        err_q  <= miss;
                        if (miss) begin
                            err_addr_q <= pr_addr;
                            err_cnt_q  <= sat_inc(err_cnt_q);
                        end
                    end
                end
                BR_ACCESS: begin
                    if (ack_sel) begin
                        rd_q  <= (we_q == 4'b0000) ? rd_mux : 32'h0;
                        err_q <= 1'b0;
                    end else if (expired) begin
                        rd_q       <= '0;
                        err_q      <= 1'b1;
                        err_addr_q <= addr_q;
                        err_cnt_q  <= sat_inc(err_cnt_q);
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pr_ready = (state_q == BR_RESP);
    assign pr_err   = pr_ready & err_q;
    assign pr_rd    = rd_q;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;
    assign dev_addr = addr_q;
    assign dev_wd   = wd_q;
    assign dev_we   = in_access ? we_q : 4'b0000;
    assign dev_sel  = in_access ? sel_q : '0;

endmodule

// File: tb/tb_bus_bridge_mux.sv
// Scoreboard bench for bus_bridge_mux: directed accesses push expected responses,
// a monitor pops and compares them whenever pr_ready is presented.
module tb_bus_bridge_mux;
    import bridge_pkg::*;

    localparam int N_DEV   = 4;
    localparam int TIMEOUT = 15;

    logic                clk      = 1'b0;
    logic                reset_n  = 1'b0;
    logic                pr_req   = 1'b0;
    logic [31:0]         pr_addr  = '0;
    logic [31:0]         pr_wd    = '0;
    logic [3:0]          pr_we    = '0;
    logic                pr_ready;
    logic [31:0]         pr_rd;
    logic                pr_err;
    logic [31:0]         err_addr;
    logic [7:0]          err_cnt;
    logic [31:0]         dev_addr;
    logic [31:0]         dev_wd;
    logic [3:0]          dev_we;
    logic [N_DEV-1:0]    dev_sel;
    logic [N_DEV-1:0]    dev_ack  = '0;
    logic [N_DEV*32-1:0] dev_rd;

    assign dev_rd = {32'hC3C3_0003, 32'hB2B2_0002, 32'hA1A1_0001, 32'hDEAD_BEEF};

    bus_bridge_mux #(
        .N_DEV   (N_DEV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pr_req   (pr_req),
        .pr_addr  (pr_addr),
        .pr_wd    (pr_wd),
        .pr_we    (pr_we),
        .pr_ready (pr_ready),
        .pr_rd    (pr_rd),
        .pr_err   (pr_err),
        .err_addr (err_addr),
        .err_cnt  (err_cnt),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_we   (dev_we),
        .dev_sel  (dev_sel),
        .dev_ack  (dev_ack),
        .dev_rd   (dev_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    int         ack_ch     = -1;
    int         ack_wait   = 0;
    logic [3:0] stray_mask = 4'b0000;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%08h want=0x%08h", name, got, want);
        end
    endtask

    // Device model: the chosen channel acks after ack_wait wait cycles; stray_mask acks always.
    initial begin
        int sel_cnt;
        sel_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (dev_sel != '0) sel_cnt++;
            else sel_cnt = 0;
            dev_ack = stray_mask;
            if (ack_ch >= 0 && sel_cnt == ack_wait + 1 && dev_sel[ack_ch]) dev_ack[ack_ch] = 1'b1;
        end
    end

    // Response monitor.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (pr_ready === 1'b1) begin
                check("ready_width", {31'b0, prev}, 32'd0);
                if (sb_q.size() == 0) begin
                    check("sb_nonempty", sb_q.size(), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_rd", pr_rd, e.rd);
                    check("resp_err", {31'b0, pr_err}, {31'b0, e.err});
                end
            end
            prev = pr_ready;
        end
    end

    // Issue one access from an IDLE cycle and follow it to pr_ready.
    task automatic do_access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] we, input logic [31:0] exp_rd, input logic exp_err,
                             input logic [3:0] exp_sel, input int exp_sel_cyc, input int exp_lat);
        int   lat;
        int   sel_cyc;
        int   bad_sel;
        int   bad_bus;
        logic done;
        lat = 0; sel_cyc = 0; bad_sel = 0; bad_bus = 0; done = 1'b0;
        sb_q.push_back('{rd: exp_rd, err: exp_err});
        pr_req = 1'b1; pr_addr = a; pr_wd = wd; pr_we = we;
        while (!done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (dev_sel != '0) begin
                if (dev_sel == exp_sel) sel_cyc++;
                else bad_sel++;
                if (dev_we !== we || dev_wd !== wd || dev_addr !== a) bad_bus++;
            end else if (dev_we !== 4'b0000) begin
                bad_bus++;
            end
            if (pr_ready === 1'b1) done = 1'b1;
        end
        pr_req = 1'b0; pr_we = 4'b0000;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_sel_cycles"}, sel_cyc, exp_sel_cyc);
        check({tag, "_sel_wrong"}, bad_sel, 32'd0);
        check({tag, "_bus"}, bad_bus, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gap;
        int seen;
        int bad_gap;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pr_ready", {31'b0, pr_ready}, 32'd0);
        check("rst_pr_rd", pr_rd, 32'd0);
        check("rst_pr_err", {31'b0, pr_err}, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check("rst_dev_sel", {28'b0, dev_sel}, 32'd0);
        check("rst_dev_addr", dev_addr, 32'd0);
        check("rst_dev_wd", dev_wd, 32'd0);
        check("rst_dev_we", {28'b0, dev_we}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        ack_ch = 0; ack_wait = 0;
        do_access("rd0", 32'h0000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 4'b0001, 1, 2);

        ack_ch = 1; ack_wait = 3;
        do_access("wr1", 32'h0000_7F04, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 4'b0010, 4, 5);

        ack_ch = -1;
        do_access("miss", 32'h0000_4000, 32'h0, 4'b0000, 32'h0, 1'b1, 4'b0000, 0, 1);
        check("miss_err_addr", err_addr, 32'h0000_4000);
        check("miss_err_cnt", {24'b0, err_cnt}, 32'd1);

        ack_ch = 2; ack_wait = 1;
        do_access("rd2_top", 32'h0000_7F1B, 32'h0, 4'b0000, 32'hB2B2_0002, 1'b0, 4'b0100, 2, 3);

        ack_ch = -1;
        do_access("gap", 32'h0000_7F0C, 32'h0, 4'b0000, 32'h0, 1'b1, 4'b0000, 0, 1);
        check("gap_err_cnt", {24'b0, err_cnt}, 32'd2);

        ack_ch = -1; stray_mask = 4'b0001;
        do_access("tmo", 32'h0000_7F20, 32'h0, 4'b0000, 32'h0, 1'b1, 4'b1000, TIMEOUT + 1, TIMEOUT + 2);
        check("tmo_err_addr", err_addr, 32'h0000_7F20);
        check("tmo_err_cnt", {24'b0, err_cnt}, 32'd3);

        ack_ch = 3; ack_wait = 0;
        do_access("rd3_stray", 32'h0000_7F23, 32'h0, 4'b0000, 32'hC3C3_0003, 1'b0, 4'b1000, 1, 2);
        stray_mask = 4'b0000; ack_ch = -1;

        gap = 0; seen = 0; bad_gap = 0;
        sb_q.push_back('{rd: 32'h0, err: 1'b1});
        pr_req = 1'b1; pr_addr = 32'hFFFF_0000; pr_we = 4'b0000;
        while (seen < 300 && gap < 8) begin
            @(posedge clk);
            #1;
            gap++;
            if (pr_ready === 1'b1) begin
                if (gap != ((seen == 0) ? 1 : 2)) bad_gap++;
                seen++;
                gap = 0;
                if (seen < 300) sb_q.push_back('{rd: 32'h0, err: 1'b1});
            end
        end
        pr_req = 1'b0;
        check("b2b_count", seen, 32'd300);
        check("b2b_spacing", bad_gap, 32'd0);
        @(posedge clk);
        #1;
        check("sat_err_cnt", {24'b0, err_cnt}, 32'd255);
        check("sat_err_addr", err_addr, 32'hFFFF_0000);

        pr_req = 1'b1; pr_addr = 32'h0000_7F00; pr_we = 4'b0000;
        @(posedge clk);
        #1;
        pr_req = 1'b0;
        @(posedge clk);
        #1;
        check("abort_sel_before", {28'b0, dev_sel}, 32'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_dev_sel", {28'b0, dev_sel}, 32'd0);
        check("abort_pr_ready", {31'b0, pr_ready}, 32'd0);
        check("abort_err_cnt", {24'b0, err_cnt}, 32'd0);
        check("abort_dev_we", {28'b0, dev_we}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        ack_ch = 0; ack_wait = 0;
        do_access("post_rst", 32'h0000_0000, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 4'b0001, 1, 2);
        check("post_rst_err_cnt", {24'b0, err_cnt}, 32'd0);

        repeat (2) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
